wide_add_sched: RTL and testbench

Multi-cycle scheduler that shares one 16-bit Kogge-Stone `adder` instance between two requesters. It performs WORDS×16-bit add or subtract by feeding the adder one 16-bit limb per cycle, LSB limb first, and chaining `cout` into the next `cin` through a carry register. Requests are arbitrated round-robin, one operation is in flight at a time, and results return on a valid/ready response port tagged with the requester id.

---
 rtl/wide_add_pkg.sv | 19 +
 rtl/adder.sv | 52 +++++
 rtl/wide_add_sched.sv | 121 ++++++++++++
 tb/tb_wide_add_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// Shared types and helpers for the limb-serial wide adder scheduler.
package wide_add_pkg;

    localparam int LIMB_W    = 16;
    localparam int MAX_WORDS = 16;
    localparam int MAX_W     = LIMB_W * MAX_WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Pick 16-bit limb k out of a zero-extended operand.
    function automatic logic [LIMB_W-1:0] limb_sel(input logic [MAX_W-1:0] v, input logic [3:0] k);
        return v[int'(k)*LIMB_W +: LIMB_W];
    endfunction

endpackage

// File: rtl/adder.sv
// 16-bit Kogge-Stone adder with carry in/out; bit 1 is the LSB.
module adder (
    input  logic a1,  input logic a2,  input logic a3,  input logic a4,
    input  logic a5,  input logic a6,  input logic a7,  input logic a8,
    input  logic a9,  input logic a10, input logic a11, input logic a12,
    input  logic a13, input logic a14, input logic a15, input logic a16,
    input  logic b1,  input logic b2,  input logic b3,  input logic b4,
    input  logic b5,  input logic b6,  input logic b7,  input logic b8,
    input  logic b9,  input logic b10, input logic b11, input logic b12,
    input  logic b13, input logic b14, input logic b15, input logic b16,
    input  logic cin,
    output logic s1,  output logic s2,  output logic s3,  output logic s4,
    output logic s5,  output logic s6,  output logic s7,  output logic s8,
    output logic s9,  output logic s10, output logic s11, output logic s12,
    output logic s13, output logic s14, output logic s15, output logic s16,
    output logic cout
);

    logic [15:0] w_a, w_b, w_s;
    logic [15:0] w_gg, w_pp, w_gn, w_pn;
    logic [16:0] w_c;

    assign w_a = {a16, a15, a14, a13, a12, a11, a10, a9, a8, a7, a6, a5, a4, a3, a2, a1};
    assign w_b = {b16, b15, b14, b13, b12, b11, b10, b9, b8, b7, b6, b5, b4, b3, b2, b1};

    // Log-depth prefix tree: after the last level w_gg/w_pp span bits [i:0].
    always_comb begin
        w_gg = w_a & w_b;
        w_pp = w_a ^ w_b;
        w_gn = w_gg;
        w_pn = w_pp;
        for (int d = 1; d < 16; d = d * 2) begin
            w_gn = w_gg;
            w_pn = w_pp;
            for (int i = d; i < 16; i++) begin
                w_gn[i] = w_gg[i] | (w_pp[i] & w_gg[i-d]);
                w_pn[i] = w_pp[i] & w_pp[i-d];
            end
            w_gg = w_gn;
            w_pp = w_pn;
        end
        w_c[0] = cin;
        for (int i = 0; i < 16; i++) begin
            w_c[i+1] = w_gg[i] | (w_pp[i] & cin);
        end
    end

    assign w_s  = w_a ^ w_b ^ w_c[15:0];
    assign cout = w_c[16];
    assign {s16, s15, s14, s13, s12, s11, s10, s9, s8, s7, s6, s5, s4, s3, s2, s1} = w_s;

endmodule

// File: rtl/wide_add_sched.sv
// Two-requester round-robin scheduler running WORDS x 16-bit add/sub
// through one shared 16-bit adder, one limb per cycle, LSB limb first.
module wide_add_sched
    import wide_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [LIMB_W*WORDS-1:0] req0_a,
    input  logic [LIMB_W*WORDS-1:0] req0_b,
    input  logic                    req0_sub,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [LIMB_W*WORDS-1:0] req1_a,
    input  logic [LIMB_W*WORDS-1:0] req1_b,
    input  logic                    req1_sub,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [LIMB_W*WORDS-1:0] rsp_sum,
    output logic                    rsp_cout,
    output logic                    rsp_ovf
);

    localparam int W = LIMB_W * WORDS;

    state_t          r_state, w_next;
    logic            r_prio, r_carry, r_sub, r_id;
    logic [3:0]      r_k;
    logic [W-1:0]    r_a, r_b, r_sum;

    logic            w_gnt0, w_gnt1, w_take, w_last, w_cin, w_cout;
    logic [LIMB_W-1:0] w_la, w_lb, w_s;
    logic [MAX_W-1:0]  w_a_ext, w_b_ext;

    // prio=1 favours requester 1 when both are valid.
    assign w_gnt0     = req0_valid & (~req1_valid | ~r_prio);
    assign w_gnt1     = req1_valid & (~req0_valid |  r_prio);
    assign req0_ready = (r_state == IDLE) & w_gnt0;
    assign req1_ready = (r_state == IDLE) & w_gnt1;
    assign w_take     = req0_ready | req1_ready;
    assign w_last     = (r_k == 4'(WORDS - 1));

    always_comb begin
        w_a_ext          = '0;
        w_b_ext          = '0;
        w_a_ext[W-1:0]   = r_a;
        w_b_ext[W-1:0]   = r_b;
    end

    assign w_la  = limb_sel(w_a_ext, r_k);
    assign w_lb  = limb_sel(w_b_ext, r_k);
    assign w_cin = (r_k == 4'd0) ? r_sub : r_carry;

    adder u_adder (
        .a1 (w_la[0]),  .a2 (w_la[1]),  .a3 (w_la[2]),  .a4 (w_la[3]),
        .a5 (w_la[4]),  .a6 (w_la[5]),  .a7 (w_la[6]),  .a8 (w_la[7]),
        .a9 (w_la[8]),  .a10(w_la[9]),  .a11(w_la[10]), .a12(w_la[11]),
        .a13(w_la[12]), .a14(w_la[13]), .a15(w_la[14]), .a16(w_la[15]),
        .b1 (w_lb[0]),  .b2 (w_lb[1]),  .b3 (w_lb[2]),  .b4 (w_lb[3]),
        .b5 (w_lb[4]),  .b6 (w_lb[5]),  .b7 (w_lb[6]),  .b8 (w_lb[7]),
        .b9 (w_lb[8]),  .b10(w_lb[9]),  .b11(w_lb[10]), .b12(w_lb[11]),
        .b13(w_lb[12]), .b14(w_lb[13]), .b15(w_lb[14]), .b16(w_lb[15]),
        .cin(w_cin),
        .s1 (w_s[0]),   .s2 (w_s[1]),   .s3 (w_s[2]),   .s4 (w_s[3]),
        .s5 (w_s[4]),   .s6 (w_s[5]),   .s7 (w_s[6]),   .s8 (w_s[7]),
        .s9 (w_s[8]),   .s10(w_s[9]),   .s11(w_s[10]),  .s12(w_s[11]),
        .s13(w_s[12]),  .s14(w_s[13]),  .s15(w_s[14]),  .s16(w_s[15]),
        .cout(w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_take)    w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (rsp_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    // Operands are captured with B already inverted for subtract; cin=sub supplies the +1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio  <= 1'b0;
            r_k     <= 4'd0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_id    <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_take) begin
                r_id   <= req1_ready;
                r_prio <= req0_ready;
                r_sub  <= req1_ready ? req1_sub : req0_sub;
                r_a    <= req1_ready ? req1_a : req0_a;
                r_b    <= req1_ready ? (req1_sub ? ~req1_b : req1_b)
                                     : (req0_sub ? ~req0_b : req0_b);
                r_k    <= 4'd0;
            end
        end else if (r_state == RUN) begin
            r_sum[int'(r_k)*LIMB_W +: LIMB_W] <= w_s;
            r_carry <= w_cout;
            r_k     <= r_k + 4'd1;
        end
    end

    assign rsp_valid = (r_state == DONE);
    assign rsp_id    = rsp_valid & r_id;
    assign rsp_sum   = rsp_valid ? r_sum : '0;
    assign rsp_cout  = rsp_valid & r_carry;
    assign rsp_ovf   = rsp_valid & (r_a[W-1] == r_b[W-1]) & (r_sum[W-1] != r_a[W-1]);

endmodule

// File: tb/tb_wide_add_sched.sv
// Scoreboard bench for wide_add_sched with WORDS=4: arithmetic reference model, arbiter model, latency/stability checks.
module tb_wide_add_sched;

    localparam int WORDS = 4;
    localparam int W     = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_sub = 1'b0, req1_sub = 1'b0;
    logic         rsp_valid, rsp_id, rsp_cout, rsp_ovf;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_sum;

    always #5 clk = ~clk;

    wide_add_sched #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
    );

    typedef struct {
        bit           id;
        logic [W-1:0] sum;
        bit           cout;
        bit           ovf;
        int           cyc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0, bad = 0, cyc = 0, n_rsp = 0, last_acc = -1;
    bit   ii_chk = 1'b0, mprio = 1'b0, hs0_s = 1'b0, hs1_s = 1'b0, rnd_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s (cyc %0d)", nm, cyc);
    endtask

    // Reference: plain modular/signed arithmetic on whole operands.
    function automatic exp_t model(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input bit sub, input int c);
        exp_t e;
        logic [W:0] t;
        logic signed [W+1:0] full;
        e.id  = id;
        e.cyc = c;
        if (sub) begin
            e.sum  = a - b;
            e.cout = (a >= b);
            full   = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
        end else begin
            t      = {1'b0, a} + {1'b0, b};
            e.sum  = t[W-1:0];
            e.cout = t[W];
            full   = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
        end
        e.ovf = (full != $signed({{2{e.sum[W-1]}}, e.sum}));
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return {32'h0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Request-side observer: predicts grant and pushes expected responses.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!ii_chk) last_acc = -1;
            hs0_s = req0_valid & req0_ready;
            hs1_s = req1_valid & req1_ready;
            if (rst) begin
                sbq.delete();
                mprio = 1'b0;
                hs0_s = 1'b0;
                hs1_s = 1'b0;
            end else if (hs0_s | hs1_s) begin
                bit eid;
                eid = (req0_valid & req1_valid) ? mprio : req1_valid;
                chk("grant_id", 64'(hs1_s), 64'(eid));
                chk("single_grant", 64'(hs0_s & hs1_s), 64'd0);
                if (eid) sbq.push_back(model(1'b1, req1_a, req1_b, req1_sub, cyc));
                else     sbq.push_back(model(1'b0, req0_a, req0_b, req0_sub, cyc));
                mprio = ~eid;
                if (ii_chk && last_acc >= 0) chk("init_interval", 64'(cyc - last_acc), 64'd6);
                last_acc = cyc;
            end
        end
    end

    // Response monitor.
    initial begin
        exp_t e, cap;
        bit   holding;
        holding = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                holding = 1'b0;
            end else if (rsp_valid) begin
                chk("busy_ready", 64'({req0_ready, req1_ready}), 64'd0);
                if (!holding) begin
                    if (sbq.size() == 0) begin
                        fail("unexpected_rsp");
                    end else begin
                        e = sbq.pop_front();
                        chk("rsp_id", 64'(rsp_id), 64'(e.id));
                        chk("rsp_sum", rsp_sum, e.sum);
                        chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
                        chk("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
                        chk("latency", 64'(cyc - e.cyc), 64'd5);
                    end
                    cap.id   = rsp_id;
                    cap.sum  = rsp_sum;
                    cap.cout = rsp_cout;
                    cap.ovf  = rsp_ovf;
                    n_rsp++;
                end else begin
                    chk("hold_sum", rsp_sum, cap.sum);
                    chk("hold_meta", 64'({rsp_id, rsp_cout, rsp_ovf}), 64'({cap.id, cap.cout, cap.ovf}));
                end
                holding = !rsp_ready;
            end else if (holding) begin
                fail("rsp_dropped");
                holding = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (rnd_ready) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit sub);
        int g;
        g = 0;
        step();
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub; end
        #2;
        while (!(id ? hs1_s : hs0_s) && g < 100) begin
            step();
            #2;
            g++;
        end
        if (g >= 100) fail("accept_timeout");
        step();
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((sbq.size() != 0 || rsp_valid) && g < 200) begin
            step();
            g++;
        end
        if (g >= 200) fail("drain_timeout");
    endtask

    logic [W-1:0] da [5] = '{64'h0000_0000_0000_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'h7FFF_FFFF_FFFF_FFFF, 64'd5, 64'd7};
    logic [W-1:0] db [5] = '{64'd1, 64'd1, 64'd1, 64'd7, 64'd5};
    bit           ds [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int g, n, base;
        bit ch0, ch1;

        repeat (3) step();
        #3;
        chk("reset_ctrl", 64'({rsp_valid, rsp_id, rsp_cout, rsp_ovf, req0_ready, req1_ready}), 64'd0);
        chk("reset_sum", rsp_sum, '0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            send(1'b0, da[i], db[i], ds[i]);
            drain();
        end

        // Backpressure with a competing request waiting.
        rsp_ready = 1'b0;
        send(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
        g = 0;
        while (!rsp_valid && g < 20) begin step(); g++; end
        if (g >= 20) fail("bp_valid_timeout");
        req1_valid = 1'b1; req1_a = 64'hAAAA_0000_5555_FFFF; req1_b = 64'h0000_FFFF_0000_0001; req1_sub = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #2;
            chk("bp_no_accept", 64'(hs1_s), 64'd0);
            step();
        end
        rsp_ready = 1'b1;
        #2;
        chk("bp_release_cycle", 64'(hs1_s), 64'd0);
        step();
        #2;
        chk("bp_next_accept", 64'(hs1_s), 64'd1);
        step();
        req1_valid = 1'b0;
        drain();

        // Both requesters continuously valid.
        ii_chk = 1'b1;
        n = 0; g = 0; ch0 = 1'b1; ch1 = 1'b1;
        while (n < 12 && g < 300) begin
            step();
            if (ch0) begin req0_a = pick(); req0_b = pick(); req0_sub = 1'($urandom_range(0, 1)); req0_valid = 1'b1; ch0 = 1'b0; end
            if (ch1) begin req1_a = pick(); req1_b = pick(); req1_sub = 1'($urandom_range(0, 1)); req1_valid = 1'b1; ch1 = 1'b0; end
            #2;
            if (hs0_s) begin ch0 = 1'b1; n++; end
            if (hs1_s) begin ch1 = 1'b1; n++; end
            g++;
        end
        if (n < 12) fail("arb_timeout");
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        ii_chk = 1'b0;
        drain();

        // Reset in the middle of RUN.
        base = n_rsp;
        send(1'b1, 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0);
        rst = 1'b1;
        step();
        #3;
        chk("midrst_ctrl", 64'({rsp_valid, rsp_id, rsp_cout, rsp_ovf, req0_ready, req1_ready}), 64'd0);
        chk("midrst_sum", rsp_sum, '0);
        rst = 1'b0;
        repeat (10) step();
        chk("no_rsp_after_rst", 64'(n_rsp - base), 64'd0);
        send(1'b0, 64'h0000_FFFF_FFFF_0001, 64'h0000_0000_0001_FFFF, 1'b0);
        drain();

        // Random traffic with random consumer stalls.
        rnd_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            send(1'($urandom_range(0, 1)), pick(), pick(), 1'($urandom_range(0, 1)));
        end
        drain();
        rnd_ready = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) step();
        chk("all_rsp_seen", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
